// File: rtl/sm3_add_pkg.sv
// Shared types and helpers for the SM3 modular-add scheduler.
// Holds the FSM state encoding, the word width and the packed-operand slicer.
package sm3_add_pkg;

   localparam int WORD_W   = 32;
   localparam int MAX_NREQ = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD1 = 2'd1,
      ADD2 = 2'd2,
      RESP = 2'd3
   } state_e;

   // Callers zero-pad their packed buses to MAX_NREQ words before slicing.
   function automatic logic [WORD_W-1:0] word_slice(
      input logic [MAX_NREQ*WORD_W-1:0] bus,
      input int                         k
   );
      return bus[k*WORD_W +: WORD_W];
   endfunction

endpackage

// File: rtl/adder_32b.sv
// 32-bit modular adder; the carry out is discarded.
module adder_32b (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] sum
);

   assign sum = a + b;

endmodule

// File: rtl/sm3_rr_arb.sv
// Round-robin arbiter: searches upward from ptr+1 with wrap-around.
// Produces a one-hot grant, its index, and whether any request is valid.
module sm3_rr_arb #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  grant_idx,
   output logic            any
);

   int idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      idx       = 0;
      for (int i = 1; i <= NREQ; i++) begin
         idx = (int'(ptr) + i) % NREQ;
         if (!any && req[idx]) begin
            any        = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = IDW'(idx);
         end
      end
   end

endmodule

// File: rtl/sm3_add_sched.sv
// Shares one 32-bit modular adder among NREQ requesters of the SM3 datapath.
// Round-robin accept, 2- or 3-operand accumulation, valid/ready response port.
module sm3_add_sched
   import sm3_add_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [NREQ-1:0]        req_valid_i,
   output logic [NREQ-1:0]        req_ready_o,
   input  logic [NREQ*WORD_W-1:0] req_a_i,
   input  logic [NREQ*WORD_W-1:0] req_b_i,
   input  logic [NREQ*WORD_W-1:0] req_c_i,
   input  logic [NREQ-1:0]        req_three_i,
   output logic                   resp_valid_o,
   input  logic                   resp_ready_i,
   output logic [WORD_W-1:0]      resp_data_o,
   output logic [IDW-1:0]         resp_id_o,
   output logic                   busy_o
);

   state_e                    state, state_nxt;
   logic [IDW-1:0]            ptr;
   logic [IDW-1:0]            id_q;
   logic [WORD_W-1:0]         a_q, b_q, c_q, acc;
   logic                      three_q;

   logic [NREQ-1:0]           grant;
   logic [IDW-1:0]            grant_idx;
   logic                      grant_any;
   logic                      accept;

   logic [MAX_NREQ*WORD_W-1:0] a_ext, b_ext, c_ext;
   logic [WORD_W-1:0]         add_x, add_y, add_sum;

   sm3_rr_arb #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .req       (req_valid_i),
      .ptr       (ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any       (grant_any)
   );

   adder_32b u_add (
      .a   (add_x),
      .b   (add_y),
      .sum (add_sum)
   );

   always_comb begin
      a_ext = '0;
      b_ext = '0;
      c_ext = '0;
      a_ext[NREQ*WORD_W-1:0] = req_a_i;
      b_ext[NREQ*WORD_W-1:0] = req_b_i;
      c_ext[NREQ*WORD_W-1:0] = req_c_i;
   end

   // Next state, accept handshake and adder operand selection.
   always_comb begin
      state_nxt   = state;
      req_ready_o = '0;
      accept      = 1'b0;
      add_x       = a_q;
      add_y       = b_q;
      case (state)
         IDLE: begin
            if (grant_any) begin
               req_ready_o = grant;
               accept      = 1'b1;
               state_nxt   = ADD1;
            end
         end
         ADD1: state_nxt = three_q ? ADD2 : RESP;
         ADD2: begin
            add_x     = acc;
            add_y     = c_q;
            state_nxt = RESP;
         end
         RESP: begin
            if (resp_ready_i) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state   <= IDLE;
         ptr     <= IDW'(NREQ-1);
         id_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         three_q <= 1'b0;
         acc     <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            a_q     <= word_slice(a_ext, int'(grant_idx));
            b_q     <= word_slice(b_ext, int'(grant_idx));
            c_q     <= word_slice(c_ext, int'(grant_idx));
            three_q <= req_three_i[grant_idx];
            id_q    <= grant_idx;
            ptr     <= grant_idx;
         end
         if (state == ADD1 || state == ADD2) acc <= add_sum;
      end
   end

   assign resp_valid_o = (state == RESP);
   assign resp_data_o  = acc;
   assign resp_id_o    = id_q;
   assign busy_o       = (state != IDLE);

endmodule

// File: tb/tb_sm3_add_sched.sv
// Directed bench for sm3_add_sched: reset, latency, wrap-around, round-robin,
// backpressure, mid-operation reset and a mixed 2/3-operand stream.
module tb_sm3_add_sched;

   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic                 clk_i = 1'b0;
   logic                 rst_i;
   logic [NREQ-1:0]      req_valid_i;
   logic [NREQ-1:0]      req_ready_o;
   logic [NREQ*32-1:0]   req_a_i, req_b_i, req_c_i;
   logic [NREQ-1:0]      req_three_i;
   logic                 resp_valid_o;
   logic                 resp_ready_i;
   logic [31:0]          resp_data_o;
   logic [IDW-1:0]       resp_id_o;
   logic                 busy_o;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk_i = ~clk_i;

   sm3_add_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_a_i      (req_a_i),
      .req_b_i      (req_b_i),
      .req_c_i      (req_c_i),
      .req_three_i  (req_three_i),
      .resp_valid_o (resp_valid_o),
      .resp_ready_i (resp_ready_i),
      .resp_data_o  (resp_data_o),
      .resp_id_o    (resp_id_o),
      .busy_o       (busy_o)
   );

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic three);
      req_a_i[k*32 +: 32] = a;
      req_b_i[k*32 +: 32] = b;
      req_c_i[k*32 +: 32] = c;
      req_three_i[k]      = three;
   endtask

   task automatic test_reset();
      rst_i        = 1'b1;
      req_valid_i  = '0;
      req_a_i      = '0;
      req_b_i      = '0;
      req_c_i      = '0;
      req_three_i  = '0;
      resp_ready_i = 1'b1;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      vectors++;
      if (req_ready_o !== 4'h0) begin miscompares++; $display("FAIL reset_req_ready: got %h want 0", req_ready_o); end
      vectors++;
      if (resp_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid_o); end
      vectors++;
      if (resp_data_o !== 32'h0) begin miscompares++; $display("FAIL reset_resp_data: got %h want 0", resp_data_o); end
      vectors++;
      if (resp_id_o !== 2'd0) begin miscompares++; $display("FAIL reset_resp_id: got %0d want 0", resp_id_o); end
      vectors++;
      if (busy_o !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy_o); end
      tick();
      rst_i = 1'b0;
   endtask

   task automatic test_single_2op();
      tick();
      set_req(0, 32'h0000_0001, 32'h0000_0002, 32'h0, 1'b0);
      req_valid_i = 4'b0001;
      @(negedge clk_i);
      vectors++;
      if (req_ready_o !== 4'b0001) begin miscompares++; $display("FAIL single_accept: got %b want 0001", req_ready_o); end
      tick();
      req_valid_i = '0;
      @(negedge clk_i);
      vectors++;
      if (resp_valid_o !== 1'b0 || busy_o !== 1'b1) begin
         miscompares++; $display("FAIL single_t1: valid=%b busy=%b want valid=0 busy=1", resp_valid_o, busy_o);
      end
      tick();
      @(negedge clk_i);
      vectors++;
      if (resp_valid_o !== 1'b1) begin miscompares++; $display("FAIL single_latency: valid=%b at T+2 want 1", resp_valid_o); end
      vectors++;
      if (resp_data_o !== 32'h0000_0003 || resp_id_o !== 2'd0) begin
         miscompares++; $display("FAIL single_result: data=%h id=%0d want 00000003 id 0", resp_data_o, resp_id_o);
      end
      tick();
      @(negedge clk_i);
      vectors++;
      if (busy_o !== 1'b0 || resp_valid_o !== 1'b0) begin
         miscompares++; $display("FAIL single_idle: busy=%b valid=%b want 0 0", busy_o, resp_valid_o);
      end
   endtask

   task automatic test_wrap_3op();
      tick();
      set_req(2, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0005, 1'b1);
      req_valid_i = 4'b0100;
      @(negedge clk_i);
      vectors++;
      if (req_ready_o !== 4'b0100) begin miscompares++; $display("FAIL wrap_accept: got %b want 0100", req_ready_o); end
      tick();
      req_valid_i = '0;
      for (int i = 1; i <= 2; i++) begin
         @(negedge clk_i);
         vectors++;
         if (resp_valid_o !== 1'b0) begin miscompares++; $display("FAIL wrap_early_valid: valid=%b at T+%0d want 0", resp_valid_o, i); end
         tick();
      end
      @(negedge clk_i);
      vectors++;
      if (resp_valid_o !== 1'b1) begin miscompares++; $display("FAIL wrap_latency: valid=%b at T+3 want 1", resp_valid_o); end
      vectors++;
      if (resp_data_o !== 32'h0000_0005 || resp_id_o !== 2'd2) begin
         miscompares++; $display("FAIL wrap_result: data=%h id=%0d want 00000005 id 2", resp_data_o, resp_id_o);
      end
      tick();
   endtask

   task automatic test_backpressure();
      resp_ready_i = 1'b0;
      tick();
      set_req(0, 32'h0000_0010, 32'h0000_0020, 32'h0, 1'b0);
      req_valid_i = 4'b0001;
      @(negedge clk_i);
      vectors++;
      if (req_ready_o !== 4'b0001) begin miscompares++; $display("FAIL bp_accept0: got %b want 0001", req_ready_o); end
      tick();
      set_req(1, 32'h0000_0007, 32'h0000_0008, 32'h0, 1'b0);
      req_valid_i = 4'b0010;
      @(negedge clk_i);
      vectors++;
      if (req_ready_o !== 4'b0000) begin miscompares++; $display("FAIL bp_add1_ready: got %b want 0000", req_ready_o); end
      tick();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_i);
         vectors++;
         if (resp_valid_o !== 1'b1 || resp_data_o !== 32'h0000_0030 || resp_id_o !== 2'd0 || req_ready_o !== 4'b0000) begin
            miscompares++;
            $display("FAIL bp_hold[%0d]: valid=%b data=%h id=%0d ready=%b want 1 00000030 0 0000",
                     i, resp_valid_o, resp_data_o, resp_id_o, req_ready_o);
         end
         tick();
      end
      resp_ready_i = 1'b1;
      @(negedge clk_i);
      vectors++;
      if (resp_valid_o !== 1'b1 || req_ready_o !== 4'b0000) begin
         miscompares++; $display("FAIL bp_handshake: valid=%b ready=%b want 1 0000", resp_valid_o, req_ready_o);
      end
      tick();
      @(negedge clk_i);
      vectors++;
      if (req_ready_o !== 4'b0010) begin miscompares++; $display("FAIL bp_accept1: got %b want 0010", req_ready_o); end
      tick();
      req_valid_i = '0;
      tick();
      @(negedge clk_i);
      vectors++;
      if (resp_valid_o !== 1'b1 || resp_data_o !== 32'h0000_000F || resp_id_o !== 2'd1) begin
         miscompares++; $display("FAIL bp_result1: valid=%b data=%h id=%0d want 1 0000000f 1", resp_valid_o, resp_data_o, resp_id_o);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      tick();
      set_req(3, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b1);
      req_valid_i = 4'b1000;
      @(negedge clk_i);
      vectors++;
      if (req_ready_o !== 4'b1000) begin miscompares++; $display("FAIL rstmid_accept: got %b want 1000", req_ready_o); end
      tick();
      req_valid_i = '0;
      tick();
      vectors++;
      if (busy_o !== 1'b1 || resp_valid_o !== 1'b0) begin
         miscompares++; $display("FAIL rstmid_in_add2: busy=%b valid=%b want 1 0", busy_o, resp_valid_o);
      end
      rst_i = 1'b1;
      #1;
      vectors++;
      if (resp_valid_o !== 1'b0 || busy_o !== 1'b0 || resp_data_o !== 32'h0 || resp_id_o !== 2'd0 || req_ready_o !== 4'h0) begin
         miscompares++;
         $display("FAIL rstmid_outputs: valid=%b busy=%b data=%h id=%0d ready=%b want all 0",
                  resp_valid_o, busy_o, resp_data_o, resp_id_o, req_ready_o);
      end
      repeat (2) tick();
      rst_i = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk_i);
         vectors++;
         if (resp_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            miscompares++; $display("FAIL rstmid_no_resp[%0d]: valid=%b busy=%b want 0 0", i, resp_valid_o, busy_o);
         end
         tick();
      end
   endtask

   task automatic test_round_robin();
      int order[5] = '{0, 1, 2, 3, 0};
      int n = 0;
      for (int k = 0; k < NREQ; k++) set_req(k, 32'(k * 16), 32'(k + 1), 32'h0, 1'b0);
      resp_ready_i = 1'b1;
      req_valid_i  = 4'b1111;
      for (int cyc = 0; cyc < 40 && n < 5; cyc++) begin
         @(negedge clk_i);
         if (req_ready_o !== 4'b0000) begin
            vectors++;
            if (req_ready_o !== 4'(1 << order[n])) begin
               miscompares++; $display("FAIL rr_grant[%0d]: got %b want one-hot bit %0d", n, req_ready_o, order[n]);
            end
            n++;
         end
         tick();
      end
      req_valid_i = '0;
      vectors++;
      if (n != 5) begin miscompares++; $display("FAIL rr_timeout: got %0d grants want 5", n); end
      for (int i = 0; i < 10 && busy_o; i++) tick();
   endtask

   task automatic test_random_stream();
      logic [31:0] ra[NREQ], rb[NREQ], rc[NREQ];
      logic        rt[NREQ];
      logic [31:0] exp_sum = '0;
      int exp_id = 0, exp_lat = 0, acc_cyc = 0;
      int exp_ptr = NREQ - 1;
      int last_acc = -1, last_lat = 0;
      int n_acc = 0, n_resp = 0, cyc = 0, acc_k, g;
      bit pend = 0;

      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         ra[k] = $urandom(); rb[k] = $urandom(); rc[k] = $urandom(); rt[k] = 1'($urandom_range(0, 1));
         set_req(k, ra[k], rb[k], rc[k], rt[k]);
      end
      resp_ready_i = 1'b1;
      req_valid_i  = 4'b1111;
      while (n_resp < 200 && cyc < 2000) begin
         @(negedge clk_i);
         acc_k = -1;
         if (resp_valid_o === 1'b1) begin
            vectors++;
            if (!pend || resp_data_o !== exp_sum || resp_id_o !== IDW'(exp_id)) begin
               miscompares++;
               $display("FAIL stream_result[%0d]: data=%h id=%0d want %h id %0d", n_resp, resp_data_o, resp_id_o, exp_sum, exp_id);
            end
            vectors++;
            if (cyc - acc_cyc != exp_lat) begin
               miscompares++; $display("FAIL stream_latency[%0d]: got %0d want %0d", n_resp, cyc - acc_cyc, exp_lat);
            end
            pend = 0;
            n_resp++;
         end
         if (req_ready_o !== 4'b0000) begin
            g = -1;
            for (int i = 1; i <= NREQ; i++)
               if (g < 0 && req_valid_i[(exp_ptr + i) % NREQ]) g = (exp_ptr + i) % NREQ;
            vectors++;
            if (g < 0 || req_ready_o !== 4'(1 << g)) begin
               miscompares++; $display("FAIL stream_grant[%0d]: got %b want bit %0d", n_acc, req_ready_o, g);
            end
            if (last_acc >= 0) begin
               vectors++;
               if (cyc - last_acc != last_lat + 1) begin
                  miscompares++; $display("FAIL stream_interval[%0d]: got %0d want %0d", n_acc, cyc - last_acc, last_lat + 1);
               end
            end
            if (g >= 0) begin
               exp_sum  = rt[g] ? (ra[g] + rb[g] + rc[g]) : (ra[g] + rb[g]);
               exp_id   = g;
               exp_lat  = rt[g] ? 3 : 2;
               acc_cyc  = cyc;
               last_acc = cyc;
               last_lat = exp_lat;
               exp_ptr  = g;
               acc_k    = g;
               pend     = 1;
            end
            n_acc++;
         end
         tick();
         cyc++;
         if (acc_k >= 0) begin
            ra[acc_k] = $urandom(); rb[acc_k] = $urandom(); rc[acc_k] = $urandom();
            rt[acc_k] = 1'($urandom_range(0, 1));
            set_req(acc_k, ra[acc_k], rb[acc_k], rc[acc_k], rt[acc_k]);
         end
         if (n_acc >= 200) req_valid_i = '0;
      end
      vectors++;
      if (n_resp != 200) begin miscompares++; $display("FAIL stream_timeout: got %0d responses want 200", n_resp); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_2op();
      test_wrap_3op();
      test_backpressure();
      test_reset_mid();
      test_round_robin();
      test_random_stream();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
